// File: rtl/btn_debounce.sv
// Push-button input conditioning: 2-FF synchroniser plus a per-channel debounce FSM.
// Produces a clean level and single-cycle press/release pulses for each button.
module btn_debounce #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17,
  parameter int INVERT          = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {UP, WAIT_DOWN, DOWN, WAIT_UP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t             state [NUM_BTN];
  logic [CNT_W-1:0]   cnt   [NUM_BTN];
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] raw_pol;

  // Active-low pins are flipped before synchronisation so everything downstream sees 1 = pressed.
  assign raw_pol = (INVERT != 0) ? ~btn_raw : btn_raw;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= UP;
        cnt[i]   <= '0;
      end
    end else begin
      sync1       <= raw_pol;
      sync2       <= sync1;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          UP: begin
            if (sync2[i]) begin
              state[i] <= WAIT_DOWN;
              cnt[i]   <= '0;
            end
          end
          // A bounce back to the old level wins over a counter that has just completed.
          WAIT_DOWN: begin
            if (!sync2[i]) begin
              state[i] <= UP;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]     <= DOWN;
              cnt[i]       <= '0;
              btn_level[i] <= 1'b1;
              btn_press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          DOWN: begin
            if (!sync2[i]) begin
              state[i] <= WAIT_UP;
              cnt[i]   <= '0;
            end
          end
          WAIT_UP: begin
            if (sync2[i]) begin
              state[i] <= DOWN;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]       <= UP;
              cnt[i]         <= '0;
              btn_level[i]   <= 1'b0;
              btn_release[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= UP;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule
